// File: rtl/duck_anim_sequencer.sv
// Per-duck animation sequencer: steps one duck through fly, shot, fall and done phases
// on video-frame ticks and selects the sprite/palette bank the renderer reads.
module duck_anim_sequencer #(
  parameter int unsigned FLAP_FRAMES = 3,
  parameter int unsigned FLAP_PERIOD = 6,
  parameter int unsigned SHOT_HOLD   = 30,
  parameter int unsigned FALL_FRAMES = 2,
  parameter int unsigned FALL_PERIOD = 4,
  parameter int unsigned SEL_W       = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             frame_tick,
  input  logic             spawn,
  input  logic             hit,
  input  logic             escape,
  input  logic             landed,
  output logic [SEL_W-1:0] sprite_sel,
  output logic             active,
  output logic [2:0]       state_o,
  output logic             done,
  output logic             result_hit,
  output logic             result_esc
);

  localparam int unsigned MaxFlapShot = (FLAP_PERIOD > SHOT_HOLD) ? FLAP_PERIOD : SHOT_HOLD;
  localparam int unsigned MaxPeriod   = (MaxFlapShot > FALL_PERIOD) ? MaxFlapShot : FALL_PERIOD;
  localparam int unsigned CntW        = (MaxPeriod > 1) ? $clog2(MaxPeriod) : 1;
  localparam int unsigned MaxFrames   = (FLAP_FRAMES > FALL_FRAMES) ? FLAP_FRAMES : FALL_FRAMES;
  localparam int unsigned IdxW        = (MaxFrames > 1) ? $clog2(MaxFrames) : 1;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StFly  = 3'd1,
    StShot = 3'd2,
    StFall = 3'd3,
    StDone = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             hit_q, hit_d;
  logic             esc_q, esc_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    esc_d   = esc_q;
    unique case (state_q)
      StIdle: begin
        if (spawn) begin
          state_d = StFly;
          cnt_d   = '0;
          idx_d   = '0;
          hit_d   = 1'b0;
          esc_d   = 1'b0;
        end
      end
      StFly: begin
        // hit has priority over escape when both arrive together
        if (hit) begin
          state_d = StShot;
          cnt_d   = '0;
        end else if (escape) begin
          state_d = StDone;
          esc_d   = 1'b1;
        end else if (frame_tick) begin
          if (cnt_q == CntW'(FLAP_PERIOD - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IdxW'(FLAP_FRAMES - 1)) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StShot: begin
        if (frame_tick) begin
          if (cnt_q == CntW'(SHOT_HOLD - 1)) begin
            state_d = StFall;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFall: begin
        // landing pre-empts a same-cycle tick, so the index does not advance
        if (landed) begin
          state_d = StDone;
          hit_d   = 1'b1;
        end else if (frame_tick) begin
          if (cnt_q == CntW'(FALL_PERIOD - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IdxW'(FALL_FRAMES - 1)) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered with it.
  always_comb begin
    sel_d = sel_q;
    unique case (state_d)
      StIdle:  sel_d = '0;
      StFly:   sel_d = SEL_W'(idx_d);
      StShot:  sel_d = SEL_W'(FLAP_FRAMES);
      StFall:  sel_d = SEL_W'(FLAP_FRAMES + 1) + SEL_W'(idx_d);
      default: sel_d = sel_q;
    endcase
    active_d = (state_d == StFly) || (state_d == StShot) || (state_d == StFall);
    done_d   = (state_d == StDone);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      sel_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      hit_q    <= 1'b0;
      esc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      active_q <= active_d;
      done_q   <= done_d;
      hit_q    <= hit_d;
      esc_q    <= esc_d;
    end
  end

  assign sprite_sel = sel_q;
  assign active     = active_q;
  assign state_o    = state_q;
  assign done       = done_q;
  assign result_hit = hit_q;
  assign result_esc = esc_q;

endmodule

// File: tb/tb_duck_anim_sequencer.sv
// Bench for duck_anim_sequencer: directed scenarios with literal expectations, then random
// event traffic checked every cycle against a tick-counting phase model.
module tb_duck_anim_sequencer;

  localparam int unsigned FF  = 3;
  localparam int unsigned FP  = 6;
  localparam int unsigned SH  = 30;
  localparam int unsigned LF  = 2;
  localparam int unsigned LP  = 4;
  localparam int unsigned SW  = 4;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic          spawn = 1'b0;
  logic          hit = 1'b0;
  logic          escape = 1'b0;
  logic          landed = 1'b0;
  logic [SW-1:0] sprite_sel;
  logic          active;
  logic [2:0]    state_o;
  logic          done;
  logic          result_hit;
  logic          result_esc;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  // Model: phase, ticks counted since the phase began, last sprite select, result flags.
  int   m_ph  = 0;
  int   m_t   = 0;
  int   m_sel = 0;
  logic m_rh  = 1'b0;
  logic m_re  = 1'b0;

  duck_anim_sequencer #(
    .FLAP_FRAMES(FF),
    .FLAP_PERIOD(FP),
    .SHOT_HOLD  (SH),
    .FALL_FRAMES(LF),
    .FALL_PERIOD(LP),
    .SEL_W      (SW)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_tick(frame_tick),
    .spawn     (spawn),
    .hit       (hit),
    .escape    (escape),
    .landed    (landed),
    .sprite_sel(sprite_sel),
    .active    (active),
    .state_o   (state_o),
    .done      (done),
    .result_hit(result_hit),
    .result_esc(result_esc)
  );

  always #5 Clk = ~Clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge Clk or negedge Reset_n) begin : model
    int   ph;
    int   t;
    int   sel;
    logic rh;
    logic re;
    if (!Reset_n) begin
      m_ph  <= 0;
      m_t   <= 0;
      m_sel <= 0;
      m_rh  <= 1'b0;
      m_re  <= 1'b0;
    end else begin
      ph = m_ph;
      t  = m_t;
      rh = m_rh;
      re = m_re;
      case (m_ph)
        0: if (spawn) begin ph = 1; t = 0; rh = 1'b0; re = 1'b0; end
        1: begin
          if (hit) begin ph = 2; t = 0; end
          else if (escape) begin ph = 4; re = 1'b1; end
          else if (frame_tick) t = t + 1;
        end
        2: if (frame_tick) begin
          t = t + 1;
          if (t == SH) begin ph = 3; t = 0; end
        end
        3: begin
          if (landed) begin ph = 4; rh = 1'b1; end
          else if (frame_tick) t = t + 1;
        end
        default: ph = 0;
      endcase
      case (ph)
        0:       sel = 0;
        1:       sel = (t / FP) % FF;
        2:       sel = FF;
        3:       sel = FF + 1 + (t / LP) % LF;
        default: sel = m_sel;
      endcase
      m_ph  <= ph;
      m_t   <= t;
      m_sel <= sel;
      m_rh  <= rh;
      m_re  <= re;
    end
  end

  always @(negedge Clk) begin
    if (cmp_en && Reset_n) begin
      chk("model.state", 32'(state_o), 32'(m_ph));
      chk("model.sprite_sel", 32'(sprite_sel), 32'(m_sel));
      chk("model.active", 32'(active), 32'((m_ph >= 1) && (m_ph <= 3)));
      chk("model.done", 32'(done), 32'(m_ph == 4));
      chk("model.result_hit", 32'(result_hit), 32'(m_rh));
      chk("model.result_esc", 32'(result_esc), 32'(m_re));
    end
  end

  task automatic drive(input logic t, input logic s, input logic h, input logic e,
                       input logic l);
    frame_tick = t;
    spawn      = s;
    hit        = h;
    escape     = e;
    landed     = l;
    @(negedge Clk);
    frame_tick = 1'b0;
    spawn      = 1'b0;
    hit        = 1'b0;
    escape     = 1'b0;
    landed     = 1'b0;
  endtask

  initial begin
    int exp_sel;
    repeat (3) @(negedge Clk);
    chk("rst.state", 32'(state_o), 0);
    chk("rst.sel", 32'(sprite_sel), 0);
    chk("rst.active", 32'(active), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.results", 32'({result_hit, result_esc}), 0);
    Reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Flight: flap frames advance every 6 ticks, a stray spawn is ignored.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("spawn.state", 32'(state_o), 1);
    chk("spawn.active", 32'(active), 1);
    chk("spawn.sel", 32'(sprite_sel), 0);
    for (int k = 1; k <= 19; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k < 6) exp_sel = 0;
      else if (k < 12) exp_sel = 1;
      else if (k < 18) exp_sel = 2;
      else exp_sel = 0;
      chk($sformatf("fly.tick%0d", k), 32'(sprite_sel), 32'(exp_sel));
      if (k == 3) begin
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fly.respawn_state", 32'(state_o), 1);
        chk("fly.respawn_sel", 32'(sprite_sel), 0);
      end
    end

    // Shot hold then falling frames.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("hit.state", 32'(state_o), 2);
    chk("hit.sel", 32'(sprite_sel), 3);
    for (int k = 1; k <= 30; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 29) chk("shot.tick29_state", 32'(state_o), 2);
    end
    chk("fall.state", 32'(state_o), 3);
    chk("fall.sel0", 32'(sprite_sel), 4);
    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fall.sel1", 32'(sprite_sel), 5);
    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fall.wrap", 32'(sprite_sel), 4);

    // Landing with a simultaneous tick: done pulse, no index advance.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("land.done", 32'(done), 1);
    chk("land.state", 32'(state_o), 4);
    chk("land.active", 32'(active), 0);
    chk("land.sel_hold", 32'(sprite_sel), 4);
    chk("land.results", 32'({result_hit, result_esc}), 2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("land.done_end", 32'(done), 0);
    chk("land.idle", 32'(state_o), 0);
    chk("land.hold_hit", 32'(result_hit), 1);

    // hit beats escape, then an asynchronous reset during FALL.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("hitesc.state", 32'(state_o), 2);
    chk("hitesc.sel", 32'(sprite_sel), 3);
    repeat (30) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hitesc.fall", 32'(state_o), 3);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst.state", 32'(state_o), 0);
    chk("arst.sel", 32'(sprite_sel), 0);
    chk("arst.active", 32'(active), 0);
    chk("arst.flags", 32'({done, result_hit, result_esc}), 0);
    #1 Reset_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("arst.ignore_state", 32'(state_o), 0);
    chk("arst.ignore_sel", 32'(sprite_sel), 0);

    // Escape, spawn during DONE ignored, later spawn clears the result.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("esc.done", 32'(done), 1);
    chk("esc.result", 32'({result_hit, result_esc}), 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("esc.spawn_in_done", 32'(state_o), 0);
    chk("esc.hold", 32'(result_esc), 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("esc.respawn_state", 32'(state_o), 1);
    chk("esc.respawn_clear", 32'(result_esc), 0);
    chk("esc.respawn_sel", 32'(sprite_sel), 0);

    // Random event traffic with occasional asynchronous resets.
    for (int c = 0; c < 4000; c++) begin
      frame_tick = ($urandom_range(2) == 0);
      spawn      = ($urandom_range(7) == 0);
      hit        = ($urandom_range(29) == 0);
      escape     = ($urandom_range(59) == 0);
      landed     = ($urandom_range(19) == 0);
      if ($urandom_range(499) == 0) begin
        #1 Reset_n = 1'b0;
        #1 Reset_n = 1'b1;
      end
      @(negedge Clk);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/duck_anim_sequencer.md
Name: duck_anim_sequencer

Overview:
- Per-duck animation controller for the duck sprite path. Sequences the duck through fly, shot, fall and done phases, paced by a once-per-video-frame tick.
- Drives the sprite/palette bank select that picks which duck asset ROM and palette set the pixel pipeline reads.
- Sits between game logic (spawn, hit, motion events) and the sprite renderer; one instance per on-screen duck.

Parameters:
- FLAP_FRAMES, 3, number of wing-flap sprite frames in FLY (>=1)
- FLAP_PERIOD, 6, frame_ticks per flap frame (>=1)
- SHOT_HOLD, 30, frame_ticks the "shot" sprite is held (>=1)
- FALL_FRAMES, 2, number of falling sprite frames (>=1)
- FALL_PERIOD, 4, frame_ticks per fall frame (>=1)
- SEL_W, 4, sprite_sel width; must hold FLAP_FRAMES+FALL_FRAMES

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  single-cycle pulse, once per video frame (vblank start)
- spawn  in  1  start a new duck
- hit  in  1  duck was shot (from hit detection)
- escape  in  1  duck left the play area (from motion block)
- landed  in  1  falling duck reached the ground (from motion block)
- sprite_sel  out  SEL_W  sprite/palette bank select
- active  out  1  duck is drawn (FLY, SHOT or FALL)
- state_o  out  3  current state encoding
- done  out  1  single-cycle pulse when DONE is entered
- result_hit  out  1  last duck ended by being shot
- result_esc  out  1  last duck ended by escaping

Behaviour:
- State encoding: IDLE=0, FLY=1, SHOT=2, FALL=3, DONE=4. All outputs are registered. Every response appears on the first Clk edge after the causing input is sampled high.
- Reset (asynchronous, Reset_n=0), applied at any time including mid-sequence: state IDLE, sprite_sel 0, active 0, done 0, result_hit 0, result_esc 0, all counters 0.
- Internal counters: tick_cnt, width clog2 of the maximum of the three periods; frame index.
- IDLE:
  - spawn -> FLY with tick_cnt=0 and flap index 0; result_hit and result_esc cleared.
  - hit, escape, landed and frame_tick are ignored.
- FLY:
  - sprite_sel = flap index.
  - On frame_tick, tick_cnt increments. When tick_cnt==FLAP_PERIOD-1, tick_cnt resets to 0 and the flap index advances, wrapping from FLAP_FRAMES-1 to 0.
  - hit -> SHOT with tick_cnt=0.
  - escape -> DONE with result_esc=1.
  - hit and escape in the same cycle: hit wins.
- SHOT:
  - sprite_sel = FLAP_FRAMES.
  - On frame_tick, tick_cnt increments. At SHOT_HOLD-1 the block goes to FALL with tick_cnt=0 and fall index 0.
  - hit and escape are ignored.
- FALL:
  - sprite_sel = FLAP_FRAMES+1+fall index.
  - The fall index advances every FALL_PERIOD ticks and wraps at FALL_FRAMES.
  - landed -> DONE with result_hit=1.
  - landed and frame_tick in the same cycle: landed wins and there is no index advance.
- DONE:
  - Lasts exactly one cycle: done=1, active=0, sprite_sel holds its last value. Then the block returns to IDLE.
  - spawn during DONE is ignored.
- Ignored inputs: spawn outside IDLE/DONE is ignored, so it never restarts a duck mid-flight. landed outside FALL is ignored.
- Other outputs:
  - active=1 exactly in FLY, SHOT and FALL.
  - In IDLE, sprite_sel=0.
  - result flags hold until the next accepted spawn.
- frame_tick is assumed to be at most one cycle wide; back-to-back ticks are each counted.

Test Plan:
- Reset_n pulsed low asynchronously (no Clk edge) during FALL -> state_o=0, sprite_sel=0, active=0, done=0 immediately; hit/landed asserted afterwards in IDLE -> no change.
- spawn, then 19 frame_ticks (defaults) -> active=1, sprite_sel is 0 for ticks 1-5, 1 after tick 6, 2 after tick 12, 0 after tick 18. A second spawn mid-FLY leaves the sequence unchanged.
- hit in FLY -> next cycle state_o=2, sprite_sel=3. After 30 ticks -> state_o=3, sprite_sel=4. After 4 more ticks -> 5. After 4 more ticks -> 4.
- landed in FALL -> done=1 for exactly one cycle, state_o=4 then 0, result_hit=1, result_esc=0, active=0.
- hit and escape asserted in the same cycle during FLY -> SHOT (sprite_sel=3), not DONE.
- escape alone in FLY -> done pulse, result_esc=1. A following spawn -> result_esc=0 and FLY with sprite_sel=0.
